// File: rtl/aes_mixcolumns_pkg.sv
// Shared AES column-mixing definitions: FSM state encodings, GF(2^8) reduction constant, xtime.
// Latency: none (types, constants and a combinational function only).
// Backpressure: not applicable.
package aes_mixcolumns_pkg;

   // One idle state plus one state per column being transformed.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      COL0 = 3'd1,
      COL1 = 3'd2,
      COL2 = 3'd3,
      COL3 = 3'd4
   } state_t;

   // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1.
   localparam logic [7:0] GF_REDUCE = 8'h1B;

   // Multiply by x in GF(2^8), folding the carried-out bit back in.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? GF_REDUCE : 8'h00);
   endfunction

endpackage

// File: rtl/aes_mixcolumns_if.sv
// Request/result bundle between the ShiftRows stage and the MixColumns block.
// Latency: none (wiring only).
// Backpressure: none; start_i is only honoured while the block is idle.
interface aes_mixcolumns_if;

   logic         start_i;
   logic         decrypt_i;
   logic [127:0] data_i;
   logic         ready_o;
   logic [127:0] data_o;

   modport master (
      output start_i,
      output decrypt_i,
      output data_i,
      input  ready_o,
      input  data_o
   );

   modport slave (
      input  start_i,
      input  decrypt_i,
      input  data_i,
      output ready_o,
      output data_o
   );

endinterface

// File: rtl/aes_mixcol_word.sv
// One 32-bit column through MixColumns (decrypt=0) or InvMixColumns (decrypt=1).
// Latency: purely combinational.
// Backpressure: none.
module aes_mixcol_word
   import aes_mixcolumns_pkg::*;
(
   input  logic [31:0] col_in,
   input  logic        decrypt,
   output logic [31:0] col_out
);

   logic [7:0] a  [4];
   logic [7:0] m2 [4];
   logic [7:0] m3 [4];
   logic [7:0] m4 [4];
   logic [7:0] m8 [4];
   logic [7:0] m9 [4];
   logic [7:0] mb [4];
   logic [7:0] md [4];
   logic [7:0] me [4];
   logic [7:0] enc [4];
   logic [7:0] dec [4];

   // Every constant multiple is built from doublings and XORs, so no table is needed.
   for (genvar i = 0; i < 4; i++) begin : g_byte
      localparam int J1 = (i + 1) % 4;
      localparam int J2 = (i + 2) % 4;
      localparam int J3 = (i + 3) % 4;

      assign a[i]  = col_in[31-8*i -: 8];
      assign m2[i] = xtime(a[i]);
      assign m3[i] = m2[i] ^ a[i];
      assign m4[i] = xtime(m2[i]);
      assign m8[i] = xtime(m4[i]);
      assign m9[i] = m8[i] ^ a[i];
      assign mb[i] = m8[i] ^ m2[i] ^ a[i];
      assign md[i] = m8[i] ^ m4[i] ^ a[i];
      assign me[i] = m8[i] ^ m4[i] ^ m2[i];

      assign enc[i] = m2[i] ^ m3[J1] ^ a[J2]  ^ a[J3];
      assign dec[i] = me[i] ^ mb[J1] ^ md[J2] ^ m9[J3];

      assign col_out[31-8*i -: 8] = decrypt ? dec[i] : enc[i];
   end

endmodule

// File: rtl/aes_mixcolumns.sv
// Column-serial AES (Inv)MixColumns over a 128-bit state, one column per cycle.
// Latency: 4 cycles from accepted start_i to the ready_o pulse; next block may start on the pulse.
// Backpressure: none; start_i is ignored while busy and never queued.
module aes_mixcolumns
   import aes_mixcolumns_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   aes_mixcolumns_if.slave   bus
);

   state_t       state;
   state_t       state_nxt;
   logic [127:0] data_reg;
   logic [127:0] data_nxt;
   logic         mode_reg;
   logic         mode_nxt;
   logic         ready_reg;
   logic         ready_nxt;

   logic [1:0]   col_sel;
   logic [31:0]  col_cur;
   logic [31:0]  col_new;

   // Column under work is the one named by the current COLc state.
   always_comb begin
      col_sel = 2'd0;
      case (state)
         COL0:    col_sel = 2'd0;
         COL1:    col_sel = 2'd1;
         COL2:    col_sel = 2'd2;
         COL3:    col_sel = 2'd3;
         default: col_sel = 2'd0;
      endcase
   end

   // Pick that column out of the working register (column 0 is the top word).
   always_comb begin
      col_cur = data_reg[127:96];
      case (col_sel)
         2'd0: col_cur = data_reg[127:96];
         2'd1: col_cur = data_reg[95:64];
         2'd2: col_cur = data_reg[63:32];
         2'd3: col_cur = data_reg[31:0];
         default: col_cur = data_reg[127:96];
      endcase
   end

   // Single shared column engine; the latched mode, not the live input, picks the direction.
   aes_mixcol_word u_word (
      .col_in  (col_cur),
      .decrypt (mode_reg),
      .col_out (col_new)
   );

   // Next-state logic: accept in IDLE, rewrite one column per busy state, pulse ready leaving COL3.
   always_comb begin
      state_nxt = state;
      data_nxt  = data_reg;
      mode_nxt  = mode_reg;
      ready_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start_i) begin
               data_nxt  = bus.data_i;
               mode_nxt  = bus.decrypt_i;
               state_nxt = COL0;
            end
         end
         COL0: begin
            data_nxt[127:96] = col_new;
            state_nxt        = COL1;
         end
         COL1: begin
            data_nxt[95:64] = col_new;
            state_nxt       = COL2;
         end
         COL2: begin
            data_nxt[63:32] = col_new;
            state_nxt       = COL3;
         end
         COL3: begin
            data_nxt[31:0] = col_new;
            state_nxt      = IDLE;
            ready_nxt      = 1'b1;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops any block in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         data_reg  <= '0;
         mode_reg  <= 1'b0;
         ready_reg <= 1'b0;
      end else begin
         state     <= state_nxt;
         data_reg  <= data_nxt;
         mode_reg  <= mode_nxt;
         ready_reg <= ready_nxt;
      end
   end

   assign bus.ready_o = ready_reg;
   assign bus.data_o  = data_reg;

endmodule

// File: tb/tb_aes_mixcolumns.sv
// Self-checking bench for aes_mixcolumns against a GF(2^8) multiply reference model.
// Latency: checks the 4-cycle start-to-ready timing and 5-cycle back-to-back spacing.
// Backpressure: exercises ignored start_i while busy and reset mid-block.
module tb_aes_mixcolumns;

   localparam logic [127:0] V_COL_IN  = 128'hdb135345_01010101_01010101_01010101;
   localparam logic [127:0] V_COL_OUT = 128'h8e4da1bc_01010101_01010101_01010101;
   localparam logic [127:0] V_PLAIN   = 128'hf20a225c_c6c6c6c6_d4d4d4d5_2d26314c;
   localparam logic [127:0] V_MIXED   = 128'h9fdc589d_c6c6c6c6_d5d5d7d6_4d7ebdf8;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   aes_mixcolumns_if bus ();

   aes_mixcolumns dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Field multiply by shift-and-add over the AES polynomial.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int n = 0; n < 8; n++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   // Whole-state reference: each output byte is a coefficient-weighted sum of its column.
   function automatic logic [127:0] ref_mix(input logic [127:0] blk, input logic dec);
      logic [7:0]   k [4];
      logic [7:0]   a [4];
      logic [7:0]   r;
      logic [127:0] res = '0;
      if (dec) begin
         k[0] = 8'h0E; k[1] = 8'h0B; k[2] = 8'h0D; k[3] = 8'h09;
      end else begin
         k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01;
      end
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < 4; i++) a[i] = blk[127-8*(4*c+i) -: 8];
         for (int i = 0; i < 4; i++) begin
            r = 8'h00;
            for (int j = 0; j < 4; j++) r = r ^ gmul(k[j], a[(i+j)%4]);
            res[127-8*(4*c+i) -: 8] = r;
         end
      end
      return res;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; scrambles inputs once the block is accepted.
   task automatic run_block(input logic [127:0] din, input logic dec, input string tag);
      int           cyc;
      logic [127:0] exp;
      exp           = ref_mix(din, dec);
      bus.start_i   = 1'b1;
      bus.decrypt_i = dec;
      bus.data_i    = din;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         bus.start_i   = 1'b0;
         bus.decrypt_i = ~dec;
         bus.data_i    = rnd128();
      end while (!bus.ready_o && cyc < 20);
      check_int({tag, " latency"}, cyc, 5);
      check128({tag, " data"}, bus.data_o, exp);
      @(negedge clk);
      check1({tag, " pulse width"}, bus.ready_o, 1'b0);
      check128({tag, " hold"}, bus.data_o, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      int           pulses;
      int           lat;
      int           last;
      logic [127:0] din;
      logic         dec;
      logic [127:0] exp_q [$];

      bus.start_i   = 1'b0;
      bus.decrypt_i = 1'b0;
      bus.data_i    = '0;
      reset         = 1'b0;
      repeat (3) @(negedge clk);
      check128("reset data", bus.data_o, '0);
      check1("reset ready", bus.ready_o, 1'b0);

      // Release and start on the very next edge.
      reset = 1'b1;
      run_block(V_COL_IN, 1'b0, "enc_col");
      check128("enc_col vector", bus.data_o, V_COL_OUT);
      run_block(V_PLAIN, 1'b0, "enc_blk");
      check128("enc_blk vector", bus.data_o, V_MIXED);
      run_block(V_MIXED, 1'b1, "dec_blk");
      check128("dec_blk vector", bus.data_o, V_PLAIN);

      // Idle with start low: result held, no pulse.
      pulses = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.ready_o) pulses++;
      end
      check_int("idle pulses", pulses, 0);
      check128("idle hold", bus.data_o, V_PLAIN);

      // Start and mode poked during COL1 must not disturb the block.
      bus.start_i   = 1'b1;
      bus.decrypt_i = 1'b0;
      bus.data_i    = V_PLAIN;
      pulses = 0;
      lat    = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) bus.start_i = 1'b0;
         if (k == 2) begin
            bus.start_i   = 1'b1;
            bus.decrypt_i = 1'b1;
            bus.data_i    = rnd128();
         end
         if (k == 3) begin
            bus.start_i   = 1'b0;
            bus.decrypt_i = 1'b0;
         end
         if (bus.ready_o) begin
            pulses++;
            lat = k;
            if (pulses == 1) check128("busy data", bus.data_o, V_MIXED);
         end
      end
      check_int("busy pulses", pulses, 1);
      check_int("busy latency", lat, 5);

      // Reset while in COL2 clears everything at once.
      bus.start_i   = 1'b1;
      bus.decrypt_i = 1'b0;
      bus.data_i    = V_PLAIN;
      @(negedge clk);
      bus.start_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check128("abort data", bus.data_o, '0);
      check1("abort ready", bus.ready_o, 1'b0);
      @(negedge clk);
      reset  = 1'b1;
      pulses = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.ready_o) pulses++;
      end
      check_int("abort no ready", pulses, 0);
      check128("abort stays zero", bus.data_o, '0);

      // Random blocks in both directions.
      for (int n = 0; n < 16; n++) begin
         run_block(rnd128(), 1'($urandom_range(0, 1)), "random");
      end

      // Back-to-back with start held high; new data presented on each ready pulse.
      din = V_PLAIN;
      dec = 1'b0;
      exp_q.push_back(ref_mix(din, dec));
      bus.start_i   = 1'b1;
      bus.decrypt_i = dec;
      bus.data_i    = din;
      pulses = 0;
      last   = -1;
      for (int k = 1; k <= 60 && pulses < 6; k++) begin
         @(negedge clk);
         if (bus.ready_o) begin
            pulses++;
            check128("b2b data", bus.data_o, exp_q.pop_front());
            if (last >= 0) check_int("b2b spacing", k - last, 5);
            last = k;
            if (pulses % 2 == 1) begin
               din = V_MIXED;
               dec = 1'b1;
            end else begin
               din = V_PLAIN;
               dec = 1'b0;
            end
            exp_q.push_back(ref_mix(din, dec));
            bus.decrypt_i = dec;
            bus.data_i    = din;
         end
      end
      check_int("b2b pulses", pulses, 6);
      bus.start_i = 1'b0;
      repeat (6) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
